alu_operand_sequencer: RTL

- Upstream/downstream memory stage for the ALU. It fetches two 16-bit operands byte-by-byte from the byte-wide, little-endian data memory, presents them with the opcode to the ALU over a valid/ready handshake, and writes the result back to the destination address.
- Replaces the ALU's direct multi-port memory reads with a single-port, sequenced memory interface.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/byte_word_assembler.sv | 35 +++
 rtl/alu_operand_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, byte-op select bit and sequencer state encoding shared by the ALU operand path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [7:0] ADD   = 8'd0;
  localparam logic [7:0] ADD_B = 8'd1;
  localparam logic [7:0] ADDC  = 8'd2;
  localparam logic [7:0] SUB   = 8'd4;
  localparam logic [7:0] CMP   = 8'd68;
  localparam logic [7:0] CMP_B = 8'd69;
  localparam logic [7:0] XOR   = 8'd32;
  localparam logic [7:0] AND   = 8'd16;
  localparam logic [7:0] SRA   = 8'd8;
  localparam logic [7:0] RRC   = 8'd10;

  // Opcode bit that selects a byte (.b) operation.
  localparam int BYTE_BIT = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_SRC_LO,
    S_RD_SRC_HI,
    S_RD_DST_LO,
    S_RD_DST_HI,
    S_CAPT,
    S_ISSUE,
    S_WAIT_RES,
    S_WR_LO,
    S_WR_HI,
    S_DONE,
    S_ERR
  } seq_state_t;

  // Compare opcodes only set flags inside the ALU; nothing is written back.
  function automatic logic is_cmp_op(input logic [7:0] op);
    return (op == CMP) || (op == CMP_B);
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: builds a 16-bit word from lo/hi byte loads, or loads a whole word, and exposes one byte for write-out.
// Latency: byte/word loads visible on o_word the cycle after the load strobe; o_byte is combinational from the held word.
// Backpressure: none; the owner sequences the load strobes.
// Ports: i_ld_lo/i_ld_hi + i_byte (byte assembly), i_ld_word + i_word (whole-word load, wins over byte loads),
//        i_sel_hi picks the byte on o_byte, o_word is the held word.
module byte_word_assembler (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ld_lo,
  input  logic        i_ld_hi,
  input  logic [7:0]  i_byte,
  input  logic        i_ld_word,
  input  logic [15:0] i_word,
  input  logic        i_sel_hi,
  output logic [15:0] o_word,
  output logic [7:0]  o_byte
);

  logic [15:0] r_word;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_word <= '0;
    end else if (i_ld_word) begin
      r_word <= i_word;
    end else begin
      if (i_ld_lo) r_word[7:0]  <= i_byte;
      if (i_ld_hi) r_word[15:8] <= i_byte;
    end
  end

  assign o_word = r_word;
  assign o_byte = i_sel_hi ? r_word[15:8] : r_word[7:0];

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: fetches two little-endian 16-bit operands byte-by-byte, hands them to the ALU, writes the result back.
// Latency: word op, ALU ready at once and result 1 cycle after handshake -> done 10 cycles after start is sampled.
// Backpressure: holds alu_valid with stable operands until alu_ready; waits up to RES_TIMEOUT cycles for res_valid, then err.
// Ports: i_start/i_instr/i_src_addr/i_dst_addr request (sampled in IDLE only); o_mem_* single-port byte memory, read data
//        one cycle after o_mem_rd; o_alu_*/i_alu_ready operand handshake; i_res_* ALU result; o_busy/o_done/o_err status.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int RES_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_instr,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_mem_wr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_alu_valid,
  input  logic              i_alu_ready,
  output logic [7:0]        o_alu_instr,
  output logic [15:0]       o_alu_src,
  output logic [15:0]       o_alu_dst,
  input  logic              i_res_valid,
  input  logic [15:0]       i_res_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [7:0]        TMO_LIMIT = 8'(RES_TIMEOUT);

  seq_state_t        r_state;
  logic [7:0]        r_instr;
  logic [ADDR_W-1:0] r_src_addr;
  logic [ADDR_W-1:0] r_dst_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_cnt;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_alu_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [7:0]  w_cnt_nxt;
  logic        w_res_take;
  logic [15:0] w_src_word;
  logic [15:0] w_dst_word;
  logic [7:0]  w_dst_byte;
  logic [7:0]  w_src_byte_unused;

  assign w_cnt_nxt  = r_cnt + 8'd1;
  assign w_res_take = (r_state == S_WAIT_RES) && i_res_valid;

  // Read data for the byte requested in state N arrives in state N+1, so each capture strobe trails its read by one state.
  byte_word_assembler u_src (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ld_lo   (r_state == S_RD_SRC_HI),
    .i_ld_hi   (r_state == S_RD_DST_LO),
    .i_byte    (i_mem_rdata),
    .i_ld_word (1'b0),
    .i_word    (16'h0000),
    .i_sel_hi  (1'b0),
    .o_word    (w_src_word),
    .o_byte    (w_src_byte_unused)
  );

  // The dst word is no longer needed once the result arrives, so the result overwrites it and is written out from here.
  byte_word_assembler u_dst (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ld_lo   (r_state == S_RD_DST_HI),
    .i_ld_hi   (r_state == S_CAPT),
    .i_byte    (i_mem_rdata),
    .i_ld_word (w_res_take),
    .i_word    (i_res_data),
    .i_sel_hi  (r_state == S_WR_HI),
    .o_word    (w_dst_word),
    .o_byte    (w_dst_byte)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_instr     <= '0;
      r_src_addr  <= '0;
      r_dst_addr  <= '0;
      r_mem_addr  <= '0;
      r_cnt       <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_alu_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Single-cycle strobes drop by default; each transition raises those owned by its target state.
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_instr    <= i_instr;
            r_src_addr <= i_src_addr;
            r_dst_addr <= i_dst_addr;
            r_busy     <= 1'b1;
            if (!i_instr[BYTE_BIT] && (i_src_addr[0] || i_dst_addr[0])) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state    <= S_RD_SRC_LO;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= i_src_addr;
            end
          end
        end
        S_RD_SRC_LO: begin
          r_state    <= S_RD_SRC_HI;
          r_mem_rd   <= 1'b1;
          r_mem_addr <= r_src_addr + ADDR_ONE;
        end
        S_RD_SRC_HI: begin
          r_state    <= S_RD_DST_LO;
          r_mem_rd   <= 1'b1;
          r_mem_addr <= r_dst_addr;
        end
        S_RD_DST_LO: begin
          r_state    <= S_RD_DST_HI;
          r_mem_rd   <= 1'b1;
          r_mem_addr <= r_dst_addr + ADDR_ONE;
        end
        S_RD_DST_HI: r_state <= S_CAPT;
        S_CAPT: begin
          r_state     <= S_ISSUE;
          r_alu_valid <= 1'b1;
        end
        S_ISSUE: begin
          if (i_alu_ready) begin
            r_state     <= S_WAIT_RES;
            r_alu_valid <= 1'b0;
            r_cnt       <= '0;
          end
        end
        S_WAIT_RES: begin
          r_cnt <= w_cnt_nxt;
          // A result on the last allowed cycle is still taken: res_valid is tested before the limit.
          if (i_res_valid) begin
            if (is_cmp_op(r_instr)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_WR_LO;
              r_mem_wr   <= 1'b1;
              r_mem_addr <= r_dst_addr;
            end
          end else if (w_cnt_nxt == TMO_LIMIT) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end
        end
        S_WR_LO: begin
          // Byte ops leave the destination high byte untouched.
          if (r_instr[BYTE_BIT]) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_WR_HI;
            r_mem_wr   <= 1'b1;
            r_mem_addr <= r_dst_addr + ADDR_ONE;
          end
        end
        S_WR_HI: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE, S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_addr  = r_mem_addr;
  assign o_mem_rd    = r_mem_rd;
  assign o_mem_wr    = r_mem_wr;
  assign o_mem_wdata = w_dst_byte;
  assign o_alu_valid = r_alu_valid;
  assign o_alu_instr = r_instr;
  assign o_alu_src   = w_src_word;
  assign o_alu_dst   = w_dst_word;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
